// File: rtl/npu_pkg.sv
// Shared constants, writeback FSM state type and bank decode helper.
package npu_pkg;

   localparam int LANES  = 4;
   localparam int ACC_W  = 16;
   localparam int ADDR_W = 14;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } wb_state_t;

   // One-hot select for the four write-back RAM banks.
   function automatic logic [3:0] bank_onehot(input logic [1:0] num);
      return 4'b0001 << num;
   endfunction

endpackage

// File: rtl/npu_requant.sv
// Per-lane requantizer: signed round-half-up, arithmetic right shift,
// saturation to a signed byte. Optional ReLU under macro NPU_WB_RELU_EN.
module npu_requant #(
   parameter int ACC_W = 16
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic        [3:0]       shift,
   output logic        [7:0]       q
);

   // One guard bit keeps the rounding add from overflowing.
   localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] Q_MIN = -(ACC_W+1)'(128);

   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] rnd_bias;
   logic signed [ACC_W:0] rounded;
   logic signed [ACC_W:0] shifted;

   // Round, shift, clamp (and clip negatives when ReLU is built in).
   always_comb begin
      ext      = {acc[ACC_W-1], acc};
      rnd_bias = '0;
      if (shift != 4'd0) begin
         rnd_bias = (ACC_W+1)'(1) << (shift - 4'd1);
      end
      rounded = ext + rnd_bias;
      shifted = rounded >>> shift;
      if (shifted > Q_MAX) begin
         q = 8'h7F;
      end else if (shifted < Q_MIN) begin
         q = 8'h80;
      end else begin
         q = shifted[7:0];
      end
`ifdef NPU_WB_RELU_EN
      if (shifted[ACC_W]) begin
         q = 8'h00;
      end
`endif
   end

endmodule

// File: rtl/npu_writeback.sv
// NPU result write-back: accepts LANES-wide accumulator beats, requantizes
// each lane to a byte and writes them one per cycle to the selected bank.
// Optional ReLU in the requantizer is enabled by macro NPU_WB_RELU_EN.
module npu_writeback #(
   parameter int LANES  = npu_pkg::LANES,
   parameter int ACC_W  = npu_pkg::ACC_W,
   parameter int ADDR_W = npu_pkg::ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_write_back,
   input  logic                     stop_write_back,
   input  logic [1:0]               ram_num,
   input  logic [ADDR_W-1:0]        base_addr,
   input  logic [3:0]               shift,
   input  logic                     in_valid,
   input  logic [LANES*ACC_W-1:0]   in_data,
   output logic                     in_ready,
   output logic                     wr_en,
   output logic [3:0]               wr_bank,
   output logic [ADDR_W-1:0]        ram_store_addr,
   output logic [7:0]               wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [11:0]              beat_count
);

   import npu_pkg::*;

   localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

   wb_state_t            state;
   logic [1:0]           ram_num_reg;
   logic [3:0]           shift_reg;
   logic [ADDR_W-1:0]    addr_cnt;
   logic [LIDX_W-1:0]    lane_idx;
   logic [LIDX_W-1:0]    next_idx;
   logic                 stop_pend;
   logic                 handshake;
   logic [7:0]           q_lane [LANES];
   logic [7:0]           q_reg  [LANES];

   assign handshake = in_valid && in_ready;
   assign next_idx  = lane_idx + 1'b1;

   // Requantize every lane of the incoming beat in parallel; the bytes are
   // captured on the handshake so the beat itself need not be stored.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         npu_requant #(.ACC_W(ACC_W)) u_requant (
            .acc   (in_data[gi*ACC_W +: ACC_W]),
            .shift (shift_reg),
            .q     (q_lane[gi])
         );
      end
   endgenerate

   // Write-back FSM; all outputs are registered. Lane 0 is driven straight
   // from the handshake so it appears in the cycle right after acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         ram_num_reg    <= '0;
         shift_reg      <= '0;
         addr_cnt       <= '0;
         lane_idx       <= '0;
         stop_pend      <= 1'b0;
         in_ready       <= 1'b0;
         wr_en          <= 1'b0;
         wr_bank        <= '0;
         ram_store_addr <= '0;
         wr_data        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         beat_count     <= '0;
         for (int i = 0; i < LANES; i++) begin
            q_reg[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A simultaneous stop is deliberately ignored here.
               if (start_write_back) begin
                  state       <= ST_ACTIVE;
                  ram_num_reg <= ram_num;
                  shift_reg   <= shift;
                  addr_cnt    <= base_addr;
                  beat_count  <= '0;
                  stop_pend   <= 1'b0;
                  in_ready    <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (handshake) begin
                  for (int i = 0; i < LANES; i++) begin
                     q_reg[i] <= q_lane[i];
                  end
                  beat_count     <= beat_count + 12'd1;
                  stop_pend      <= stop_write_back;
                  in_ready       <= 1'b0;
                  wr_en          <= 1'b1;
                  wr_bank        <= bank_onehot(ram_num_reg);
                  wr_data        <= q_lane[0];
                  ram_store_addr <= addr_cnt;
                  addr_cnt       <= addr_cnt + 1'b1;
                  lane_idx       <= '0;
                  state          <= ST_WRITE;
               end else if (stop_write_back) begin
                  in_ready <= 1'b0;
                  done     <= 1'b1;
                  state    <= ST_DONE;
               end
            end
            ST_WRITE: begin
               if (stop_write_back) begin
                  stop_pend <= 1'b1;
               end
               if (lane_idx == LIDX_W'(LANES-1)) begin
                  wr_en   <= 1'b0;
                  wr_bank <= '0;
                  if (stop_pend || stop_write_back) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= ST_ACTIVE;
                  end
               end else begin
                  wr_data        <= q_reg[next_idx];
                  ram_store_addr <= addr_cnt;
                  addr_cnt       <= addr_cnt + 1'b1;
                  lane_idx       <= next_idx;
               end
            end
            ST_DONE: begin
               busy      <= 1'b0;
               stop_pend <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_npu_writeback.sv
// Directed-vector bench for npu_writeback.
module tb_npu_writeback;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_write_back = 1'b0;
   logic        stop_write_back = 1'b0;
   logic [1:0]  ram_num = '0;
   logic [13:0] base_addr = '0;
   logic [3:0]  shift = '0;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_ready;
   logic        wr_en;
   logic [3:0]  wr_bank;
   logic [13:0] ram_store_addr;
   logic [7:0]  wr_data;
   logic        busy;
   logic        done;
   logic [11:0] beat_count;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int rdy_cnt = 0;
   int bank_err = 0;
   int snap;

   int          hs_q[$];
   int          done_q[$];
   int          wc_q[$];
   logic [13:0] wa_q[$];
   logic [7:0]  wd_q[$];
   logic [3:0]  wb_q[$];
   logic [7:0]  exp_d[$];

   npu_writeback dut (
      .clk              (clk),
      .reset            (reset),
      .start_write_back (start_write_back),
      .stop_write_back  (stop_write_back),
      .ram_num          (ram_num),
      .base_addr        (base_addr),
      .shift            (shift),
      .in_valid         (in_valid),
      .in_data          (in_data),
      .in_ready         (in_ready),
      .wr_en            (wr_en),
      .wr_bank          (wr_bank),
      .ram_store_addr   (ram_store_addr),
      .wr_data          (wr_data),
      .busy             (busy),
      .done             (done),
      .beat_count       (beat_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe on the falling edge: inputs seen here are consumed at the next
   // rising edge (cyc+1), outputs reflect the state after rising edge cyc.
   always @(negedge clk) begin
      if (in_valid && in_ready) hs_q.push_back(cyc + 1);
      if (in_ready) rdy_cnt++;
      if (wr_en) begin
         wa_q.push_back(ram_store_addr);
         wd_q.push_back(wr_data);
         wb_q.push_back(wr_bank);
         wc_q.push_back(cyc);
      end else if (wr_bank != 4'd0) begin
         bank_err++;
      end
      if (done) done_q.push_back(cyc);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      hs_q.delete(); done_q.delete(); wc_q.delete();
      wa_q.delete(); wd_q.delete(); wb_q.delete();
   endtask

   task automatic start_pass(input logic [1:0] bank, input logic [13:0] base,
                             input logic [3:0] sh, input logic with_stop);
      clear_logs();
      ram_num = bank; base_addr = base; shift = sh;
      start_write_back = 1'b1; stop_write_back = with_stop;
      tick();
      start_write_back = 1'b0; stop_write_back = 1'b0;
      $display("start bank=%0d base=%0d shift=%0d stop=%0b", bank, base, sh, with_stop);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic send_beat(input logic [63:0] data, input logic with_stop);
      wait_ready();
      in_valid = 1'b1; in_data = data; stop_write_back = with_stop;
      tick();
      in_valid = 1'b0; stop_write_back = 1'b0;
      $display("beat data=%016h stop=%0b", data, with_stop);
   endtask

   task automatic stop_pass();
      wait_ready();
      stop_write_back = 1'b1;
      tick();
      stop_write_back = 1'b0;
      $display("stop");
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_q.size() == 0 && n < 50) begin
         tick();
         n++;
      end
      check("done_seen", 32'(done_q.size()), 32'd1);
   endtask

   task automatic check_writes(input string tag, input logic [13:0] base, input logic [3:0] bank);
      logic [13:0] a;
      check({tag, "_count"}, 32'(wa_q.size()), 32'(exp_d.size()));
      if (wa_q.size() == exp_d.size()) begin
         for (int i = 0; i < exp_d.size(); i++) begin
            a = base + 14'(i);
            check($sformatf("%s_addr%0d", tag, i), 32'(wa_q[i]), 32'(a));
            check($sformatf("%s_data%0d", tag, i), 32'(wd_q[i]), 32'(exp_d[i]));
            check($sformatf("%s_bank%0d", tag, i), 32'(wb_q[i]), 32'(bank));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench timed out");
   end

   initial begin
      // Reset values
      tick(3);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_wr_bank", 32'(wr_bank), 32'd0);
      check("rst_addr", 32'(ram_store_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_beat_count", 32'(beat_count), 32'd0);
      reset = 1'b1;

      // Basic pass, start on the first edge after release
      start_pass(2'd2, 14'd100, 4'd0, 1'b0);
      check("p1_busy", 32'(busy), 32'd1);
      check("p1_in_ready", 32'(in_ready), 32'd1);
      send_beat({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
      stop_pass();
      wait_done();
      exp_d = '{8'd1, 8'd2, 8'd3, 8'd4};
      check_writes("p1", 14'd100, 4'b0100);
      tick(2);
      check("p1_beat_count", 32'(beat_count), 32'd1);
      check("p1_idle_busy", 32'(busy), 32'd0);
      check("p1_idle_done", 32'(done), 32'd0);

      // Rounding/saturation; start and stop together in IDLE takes the start
      start_pass(2'd0, 14'd10, 4'd2, 1'b1);
      check("p2_busy", 32'(busy), 32'd1);
      check("p2_in_ready", 32'(in_ready), 32'd1);
      send_beat({16'hFC18, 16'h03E8, 16'hFFFA, 16'h0005}, 1'b0);
      stop_pass();
      wait_done();
`ifdef NPU_WB_RELU_EN
      exp_d = '{8'h01, 8'h00, 8'h7F, 8'h00};
`else
      exp_d = '{8'h01, 8'hFF, 8'h7F, 8'h80};
`endif
      check_writes("p2", 14'd10, 4'b0001);

      // Address wrap and back-to-back beat spacing
      start_pass(2'd1, 14'd16382, 4'd0, 1'b0);
      send_beat({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
      send_beat({16'd8, 16'd7, 16'd6, 16'd5}, 1'b0);
      stop_pass();
      wait_done();
      exp_d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      check_writes("p3", 14'd16382, 4'b0010);
      check("p3_hs_count", 32'(hs_q.size()), 32'd2);
      check("p3_beat_gap", 32'(hs_q[1] - hs_q[0]), 32'd5);
      tick();
      check("p3_beat_count", 32'(beat_count), 32'd2);

      // Stop on the handshake cycle; boundary saturation at shift 0
      start_pass(2'd3, 14'd50, 4'd0, 1'b0);
      send_beat({16'hFF7F, 16'h0080, 16'h007F, 16'hFFFF}, 1'b1);
      snap = rdy_cnt;
      wait_done();
      tick(3);
      check("p4_no_ready", 32'(rdy_cnt), 32'(snap));
`ifdef NPU_WB_RELU_EN
      exp_d = '{8'h00, 8'h7F, 8'h7F, 8'h00};
`else
      exp_d = '{8'hFF, 8'h7F, 8'h7F, 8'h80};
`endif
      check_writes("p4", 14'd50, 4'b1000);
      check("p4_lane0_lat", 32'(wc_q[0] - hs_q[0]), 32'd0);
      check("p4_lane3_lat", 32'(wc_q[3] - hs_q[0]), 32'd3);
      check("p4_done_lat", 32'(done_q[0] - hs_q[0]), 32'd4);
      check("p4_busy_after", 32'(busy), 32'd0);

      // Asynchronous reset during the third write cycle
      start_pass(2'd1, 14'd300, 4'd0, 1'b0);
      send_beat({16'd9, 16'd9, 16'd9, 16'd9}, 1'b0);
      tick(2);
      check("p5_pre_wr_en", 32'(wr_en), 32'd1);
      check("p5_pre_addr", 32'(ram_store_addr), 32'd302);
      reset = 1'b0;
      #1;
      check("p5_rst_wr_en", 32'(wr_en), 32'd0);
      check("p5_rst_busy", 32'(busy), 32'd0);
      check("p5_rst_bank", 32'(wr_bank), 32'd0);
      tick();
      reset = 1'b1;
      start_pass(2'd2, 14'd700, 4'd0, 1'b0);
      send_beat({16'd40, 16'd30, 16'd20, 16'd10}, 1'b0);
      stop_pass();
      wait_done();
      exp_d = '{8'd10, 8'd20, 8'd30, 8'd40};
      check_writes("p5", 14'd700, 4'b0100);
      tick();
      check("p5_beat_count", 32'(beat_count), 32'd1);

      // Start pulse during WRITE is ignored
      start_pass(2'd3, 14'd200, 4'd0, 1'b0);
      send_beat({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
      ram_num = 2'd0; base_addr = 14'd900; start_write_back = 1'b1;
      tick();
      start_write_back = 1'b0;
      check("p6_busy", 32'(busy), 32'd1);
      send_beat({16'd8, 16'd7, 16'd6, 16'd5}, 1'b0);
      stop_pass();
      wait_done();
      exp_d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      check_writes("p6", 14'd200, 4'b1000);
      tick();
      check("p6_beat_count", 32'(beat_count), 32'd2);

      check("bank_idle_zero", 32'(bank_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
